// File: rtl/jpeg_stream_sink_if.sv
// jpeg_stream_sink_if: encoder word input and byte output handshake.
// master drives words and byte_ready; slave produces the byte stream.
interface jpeg_stream_sink_if;
   logic [31:0] JPEG_bitstream;
   logic        data_ready;
   logic [4:0]  end_of_file_bitstream_count;
   logic        eof_data_partial_ready;
   logic [7:0]  byte_data;
   logic        byte_valid;
   logic        byte_ready;
   logic        byte_last;

   modport master (
      output JPEG_bitstream,
      output data_ready,
      output end_of_file_bitstream_count,
      output eof_data_partial_ready,
      output byte_ready,
      input  byte_data,
      input  byte_valid,
      input  byte_last
   );

   modport slave (
      input  JPEG_bitstream,
      input  data_ready,
      input  end_of_file_bitstream_count,
      input  eof_data_partial_ready,
      input  byte_ready,
      output byte_data,
      output byte_valid,
      output byte_last
   );
endinterface

// File: rtl/jpeg_stream_sink.sv
// jpeg_stream_sink: buffers 32-bit encoder words and serialises them
// to bytes, flushing the final partial word and an optional EOI marker.
module jpeg_stream_sink #(
   parameter int DEPTH      = 8,
   parameter bit APPEND_EOI = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   jpeg_stream_sink_if.slave bus,
   output logic              overflow,
   output logic [6:0]        fifo_level
);
   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      STREAM, PARTIAL, EOI_FF, EOI_D9
   } state_t;

   state_t        state, state_n;
   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [6:0]    fifo_cnt;
   logic [31:0]   sh, sh_n;
   logic [2:0]    cnt, cnt_n;
   logic [31:0]   eof_word;
   logic [4:0]    eof_cnt;
   logic          pend;
   logic          fifo_empty, full, wr_en, pop;
   logic          clr_pend, refill, take, sh_word;
   logic [5:0]    eof_sum;
   logic [2:0]    eof_bytes;
   logic [31:0]   eof_forced;

   // A word sitting in the shifter still counts against capacity,
   // so a stalled sink holds exactly DEPTH words.
   assign fifo_empty = (fifo_cnt == 7'd0);
   assign sh_word    = (state == STREAM) && (cnt != 3'd0);
   assign fifo_level = fifo_cnt + {6'd0, sh_word};
   assign full       = (fifo_level == 7'(DEPTH));
   assign wr_en      = bus.data_ready && !full;
   assign take       = bus.byte_valid && bus.byte_ready;

   // Partial word: ceil(count/8) bytes, bits past count forced to 1.
   assign eof_sum    = {1'b0, eof_cnt} + 6'd7;
   assign eof_bytes  = eof_sum[5:3];
   assign eof_forced = eof_word | (32'hFFFF_FFFF >> eof_cnt);

   // Byte outputs come straight from registers so they hold while stalled.
   always_comb begin
      bus.byte_valid = (cnt != 3'd0);
      bus.byte_data  = sh[31:24];
      bus.byte_last  = 1'b0;
      unique case (state)
         STREAM: bus.byte_last = !APPEND_EOI && (cnt == 3'd1)
                                 && fifo_empty && pend
                                 && (eof_cnt == 5'd0);
         PARTIAL: bus.byte_last = !APPEND_EOI && (cnt == 3'd1);
         EOI_FF: begin
            bus.byte_valid = 1'b1;
            bus.byte_data  = 8'hFF;
         end
         EOI_D9: begin
            bus.byte_valid = 1'b1;
            bus.byte_data  = 8'hD9;
            bus.byte_last  = 1'b1;
         end
      endcase
   end

   // Next state: refill the shifter in the same cycle the last byte
   // leaves it, so the stream has no bubbles at boundaries.
   always_comb begin
      state_n  = state;
      sh_n     = sh;
      cnt_n    = cnt;
      pop      = 1'b0;
      clr_pend = 1'b0;
      refill   = 1'b0;
      unique case (state)
         STREAM: begin
            if (cnt == 3'd0 || (cnt == 3'd1 && take)) begin
               refill = 1'b1;
            end else if (take) begin
               sh_n  = {sh[23:0], 8'h00};
               cnt_n = cnt - 3'd1;
            end
         end
         PARTIAL: begin
            if (take && cnt == 3'd1) begin
               clr_pend = 1'b1;
               if (APPEND_EOI) begin
                  state_n = EOI_FF;
                  sh_n    = {sh[23:0], 8'h00};
                  cnt_n   = 3'd0;
               end else begin
                  refill = 1'b1;
               end
            end else if (take) begin
               sh_n  = {sh[23:0], 8'h00};
               cnt_n = cnt - 3'd1;
            end
         end
         EOI_FF: begin
            if (take) state_n = EOI_D9;
         end
         EOI_D9: begin
            if (take) refill = 1'b1;
         end
      endcase
      if (refill) begin
         if (!fifo_empty) begin
            pop     = 1'b1;
            sh_n    = mem[rd_ptr];
            cnt_n   = 3'd4;
            state_n = STREAM;
         end else if (pend && !clr_pend) begin
            if (eof_bytes != 3'd0) begin
               sh_n    = eof_forced;
               cnt_n   = eof_bytes;
               state_n = PARTIAL;
            end else begin
               clr_pend = 1'b1;
               sh_n     = {sh[23:0], 8'h00};
               cnt_n    = 3'd0;
               state_n  = APPEND_EOI ? EOI_FF : STREAM;
            end
         end else begin
            sh_n    = {sh[23:0], 8'h00};
            cnt_n   = 3'd0;
            state_n = STREAM;
         end
      end
   end

   // FSM state and byte shifter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= STREAM;
         sh    <= 32'd0;
         cnt   <= 3'd0;
      end else begin
         state <= state_n;
         sh    <= sh_n;
         cnt   <= cnt_n;
      end
   end

   // FIFO storage; pointers below define what is valid.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= bus.JPEG_bitstream;
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= 7'd0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + AW'(1);
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         fifo_cnt <= fifo_cnt + 7'(wr_en) - 7'(pop);
      end
   end

   // EOF capture; a new EOF may land as the old one retires.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend     <= 1'b0;
         eof_word <= 32'd0;
         eof_cnt  <= 5'd0;
      end else if (bus.eof_data_partial_ready
                   && !(pend && !clr_pend)) begin
         pend     <= 1'b1;
         eof_word <= bus.JPEG_bitstream;
         eof_cnt  <= bus.end_of_file_bitstream_count;
      end else if (clr_pend) begin
         pend <= 1'b0;
      end
   end

   // Sticky flag for any dropped word or EOF.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow <= 1'b0;
      end else if ((bus.data_ready && full)
                   || (bus.eof_data_partial_ready
                       && pend && !clr_pend)) begin
         overflow <= 1'b1;
      end
   end
endmodule
